// File: rtl/alarm_set.sv
// Alarm time setting controller: key edge detection, field-select FSM,
// BCD field editing with wrap, alarm enable toggle and idle timeout.
//
// state  | meaning
// IDLE   | not editing, edit_sel = 0
// SET_HH | editing alarm hour, edit_sel = 1
// SET_MM | editing alarm minute, edit_sel = 2
// SET_SS | editing alarm second, edit_sel = 3
module alarm_set #(
    parameter logic [7:0]  RST_HH      = 8'h07,
    parameter logic [7:0]  RST_MM      = 8'h00,
    parameter logic [7:0]  RST_SS      = 8'h00,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic       key_en,
    output logic [7:0] alarm_hh,
    output logic [7:0] alarm_mm,
    output logic [7:0] alarm_ss,
    output logic       alarm_on,
    output logic [1:0] edit_sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } state_t;

    state_t      state;
    logic        prev_mode, prev_inc, prev_dec, prev_en;
    logic [31:0] tmo_cnt;

    logic ev_mode, ev_inc, ev_dec, ev_en, any_ev;
    logic inc_only, dec_only, timeout;

    // Wrap at max and carry between BCD digits; max is 8'h23 or 8'h59.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)
            return max;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign ev_mode  = key_mode & ~prev_mode;
    assign ev_inc   = key_inc  & ~prev_inc;
    assign ev_dec   = key_dec  & ~prev_dec;
    assign ev_en    = key_en   & ~prev_en;
    assign any_ev   = ev_mode | ev_inc | ev_dec | ev_en;

    // A mode event or an inc/dec collision leaves every field untouched.
    assign inc_only = ev_inc & ~ev_dec & ~ev_mode;
    assign dec_only = ev_dec & ~ev_inc & ~ev_mode;
    assign timeout  = (state != IDLE) && (tmo_cnt == TIMEOUT_CYC - 32'd1);

    assign edit_sel = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alarm_hh  <= RST_HH;
            alarm_mm  <= RST_MM;
            alarm_ss  <= RST_SS;
            alarm_on  <= 1'b0;
            tmo_cnt   <= '0;
            prev_mode <= 1'b0;
            prev_inc  <= 1'b0;
            prev_dec  <= 1'b0;
            prev_en   <= 1'b0;
        end else begin
            prev_mode <= key_mode;
            prev_inc  <= key_inc;
            prev_dec  <= key_dec;
            prev_en   <= key_en;

            if (ev_en)
                alarm_on <= ~alarm_on;

            if (state == IDLE || any_ev || timeout)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 32'd1;

            if (ev_mode) begin
                case (state)
                    IDLE:    state <= SET_HH;
                    SET_HH:  state <= SET_MM;
                    SET_MM:  state <= SET_SS;
                    default: state <= IDLE;
                endcase
            end else if (timeout) begin
                state <= IDLE;
            end else if (inc_only || dec_only) begin
                case (state)
                    SET_HH:  alarm_hh <= inc_only ? bcd_inc(alarm_hh, 8'h23) : bcd_dec(alarm_hh, 8'h23);
                    SET_MM:  alarm_mm <= inc_only ? bcd_inc(alarm_mm, 8'h59) : bcd_dec(alarm_mm, 8'h59);
                    SET_SS:  alarm_ss <= inc_only ? bcd_inc(alarm_ss, 8'h59) : bcd_dec(alarm_ss, 8'h59);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_set.sv
// Directed self-checking bench for alarm_set with a short idle timeout.
module tb_alarm_set;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0, key_en = 1'b0;
    logic [7:0] alarm_hh, alarm_mm, alarm_ss;
    logic       alarm_on;
    logic [1:0] edit_sel;

    int vectors = 0;
    int errors  = 0;

    alarm_set #(
        .RST_HH(8'h07), .RST_MM(8'h00), .RST_SS(8'h00), .TIMEOUT_CYC(32'd16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec), .key_en(key_en),
        .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_ss(alarm_ss),
        .alarm_on(alarm_on), .edit_sel(edit_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clean key pulse: high for one edge, then low for one edge.
    task automatic press(input logic m, input logic i, input logic d, input logic e);
        key_mode = m; key_inc = i; key_dec = d; key_en = e;
        tick();
        key_mode = 0; key_inc = 0; key_dec = 0; key_en = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) tick();
        vectors++; if (alarm_hh !== 8'h07) begin errors++; $display("FAIL reset_hh got %h want 07", alarm_hh); end
        vectors++; if (alarm_mm !== 8'h00) begin errors++; $display("FAIL reset_mm got %h want 00", alarm_mm); end
        vectors++; if (alarm_ss !== 8'h00) begin errors++; $display("FAIL reset_ss got %h want 00", alarm_ss); end
        vectors++; if (alarm_on !== 1'b0)  begin errors++; $display("FAIL reset_on got %b want 0", alarm_on); end
        vectors++; if (edit_sel !== 2'd0)  begin errors++; $display("FAIL reset_sel got %0d want 0", edit_sel); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_hour_inc();
        press(1, 0, 0, 0);
        vectors++; if (edit_sel !== 2'd1) begin errors++; $display("FAIL mode_to_hh sel got %0d want 1", edit_sel); end
        press(0, 1, 0, 0);
        vectors++; if (alarm_hh !== 8'h08) begin errors++; $display("FAIL hh_inc1 got %h want 08", alarm_hh); end
        press(0, 1, 0, 0);
        vectors++; if (alarm_hh !== 8'h09) begin errors++; $display("FAIL hh_inc2 got %h want 09", alarm_hh); end
        press(0, 1, 0, 0);
        vectors++; if (alarm_hh !== 8'h10) begin errors++; $display("FAIL hh_inc3 got %h want 10", alarm_hh); end
        vectors++; if (edit_sel !== 2'd1)  begin errors++; $display("FAIL hh_sel got %0d want 1", edit_sel); end
    endtask

    task automatic test_wrap();
        press(1, 0, 0, 0);
        vectors++; if (edit_sel !== 2'd2) begin errors++; $display("FAIL mode_to_mm sel got %0d want 2", edit_sel); end
        press(0, 0, 1, 0);
        vectors++; if (alarm_mm !== 8'h59) begin errors++; $display("FAIL mm_dec_wrap got %h want 59", alarm_mm); end
        press(0, 1, 0, 0);
        vectors++; if (alarm_mm !== 8'h00) begin errors++; $display("FAIL mm_inc_wrap got %h want 00", alarm_mm); end
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        vectors++; if (edit_sel !== 2'd0) begin errors++; $display("FAIL ss_to_idle sel got %0d want 0", edit_sel); end
        press(0, 1, 0, 0);
        vectors++; if (alarm_hh !== 8'h10) begin errors++; $display("FAIL idle_inc_ignored got %h want 10", alarm_hh); end
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        vectors++; if (alarm_hh !== 8'h09) begin errors++; $display("FAIL hh_dec_borrow got %h want 09", alarm_hh); end
        repeat (9) press(0, 0, 1, 0);
        vectors++; if (alarm_hh !== 8'h00) begin errors++; $display("FAIL hh_dec_to_00 got %h want 00", alarm_hh); end
        press(0, 0, 1, 0);
        vectors++; if (alarm_hh !== 8'h23) begin errors++; $display("FAIL hh_dec_wrap got %h want 23", alarm_hh); end
        press(0, 1, 0, 0);
        vectors++; if (alarm_hh !== 8'h00) begin errors++; $display("FAIL hh_inc_wrap got %h want 00", alarm_hh); end
    endtask

    task automatic test_simultaneous();
        press(1, 1, 0, 0);
        vectors++; if (edit_sel !== 2'd2) begin errors++; $display("FAIL mode_inc sel got %0d want 2", edit_sel); end
        vectors++; if (alarm_hh !== 8'h00) begin errors++; $display("FAIL mode_inc hh got %h want 00", alarm_hh); end
        vectors++; if (alarm_mm !== 8'h00) begin errors++; $display("FAIL mode_inc mm got %h want 00", alarm_mm); end
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        vectors++; if (alarm_ss !== 8'h01) begin errors++; $display("FAIL ss_inc got %h want 01", alarm_ss); end
        press(0, 1, 1, 0);
        vectors++; if (alarm_ss !== 8'h01) begin errors++; $display("FAIL inc_dec_same got %h want 01", alarm_ss); end
    endtask

    task automatic test_hold();
        key_inc = 1;
        repeat (100) tick();
        vectors++; if (alarm_ss !== 8'h02) begin errors++; $display("FAIL hold_inc got %h want 02", alarm_ss); end
        vectors++; if (edit_sel !== 2'd0)  begin errors++; $display("FAIL hold_timeout sel got %0d want 0", edit_sel); end
        key_inc = 0;
        tick();
    endtask

    task automatic test_enable();
        press(0, 0, 0, 1);
        vectors++; if (alarm_on !== 1'b1) begin errors++; $display("FAIL en_toggle got %b want 1", alarm_on); end
        press(1, 0, 0, 1);
        vectors++; if (alarm_on !== 1'b0) begin errors++; $display("FAIL en_with_mode on got %b want 0", alarm_on); end
        vectors++; if (edit_sel !== 2'd1) begin errors++; $display("FAIL en_with_mode sel got %0d want 1", edit_sel); end
    endtask

    task automatic test_timeout();
        key_inc = 1;
        tick();
        key_inc = 0;
        vectors++; if (alarm_hh !== 8'h01) begin errors++; $display("FAIL to_inc got %h want 01", alarm_hh); end
        repeat (15) tick();
        vectors++; if (edit_sel !== 2'd1) begin errors++; $display("FAIL to_early sel got %0d want 1", edit_sel); end
        tick();
        vectors++; if (edit_sel !== 2'd0) begin errors++; $display("FAIL to_expire sel got %0d want 0", edit_sel); end
        vectors++; if (alarm_hh !== 8'h01) begin errors++; $display("FAIL to_keep_hh got %h want 01", alarm_hh); end
    endtask

    task automatic test_async_reset();
        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        repeat (18) press(0, 0, 1, 0);
        vectors++; if (alarm_mm !== 8'h42) begin errors++; $display("FAIL pre_rst_mm got %h want 42", alarm_mm); end
        vectors++; if (edit_sel !== 2'd2)  begin errors++; $display("FAIL pre_rst_sel got %0d want 2", edit_sel); end
        #2 rst_n = 0;
        #1;
        vectors++; if (alarm_hh !== 8'h07) begin errors++; $display("FAIL arst_hh got %h want 07", alarm_hh); end
        vectors++; if (alarm_mm !== 8'h00) begin errors++; $display("FAIL arst_mm got %h want 00", alarm_mm); end
        vectors++; if (alarm_ss !== 8'h00) begin errors++; $display("FAIL arst_ss got %h want 00", alarm_ss); end
        vectors++; if (edit_sel !== 2'd0)  begin errors++; $display("FAIL arst_sel got %0d want 0", edit_sel); end
        vectors++; if (alarm_on !== 1'b0)  begin errors++; $display("FAIL arst_on got %b want 0", alarm_on); end
    endtask

    task automatic test_held_through_reset();
        key_mode = 1;
        tick();
        rst_n = 1;
        tick();
        vectors++; if (edit_sel !== 2'd1) begin errors++; $display("FAIL held_key sel got %0d want 1", edit_sel); end
        repeat (3) tick();
        vectors++; if (edit_sel !== 2'd1) begin errors++; $display("FAIL held_key_once sel got %0d want 1", edit_sel); end
        key_mode = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_hour_inc();
        test_wrap();
        test_simultaneous();
        test_hold();
        test_enable();
        test_timeout();
        test_async_reset();
        test_held_through_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
